// File: rtl/led_driver_pkg.sv
// rtl/led_driver_pkg.sv - shared constants and PWM gate helper for led_driver
package led_driver_pkg;

   localparam int DEFAULT_LGHOLD = 22;
   localparam int PWM_W          = 8;
   localparam logic [PWM_W-1:0] FULL_BRIGHT = 8'hff;

   // Full brightness must be solid on, not 255/256, so it is special-cased.
   function automatic logic pwm_gate(input logic [PWM_W-1:0] ctr,
                                     input logic [PWM_W-1:0] bright);
      return (ctr < bright) || (bright == FULL_BRIGHT);
   endfunction

endpackage

// File: rtl/led_stretch.sv
// rtl/led_stretch.sv - single-channel pulse stretcher; o_active stays high while the hold counter is nonzero
module led_stretch
   import led_driver_pkg::*;
#(
   parameter int LGHOLD = DEFAULT_LGHOLD
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_pulse,
   output logic o_active
);

   localparam logic [LGHOLD-1:0] HOLD_ONE = LGHOLD'(1);

   logic [LGHOLD-1:0] hold;

   // A pulse reloads from any value, so retriggers extend the on-time.
   always_ff @(posedge i_clk) begin
      if (i_reset)
         hold <= '0;
      else if (i_pulse)
         hold <= '1;
      else if (hold != '0)
         hold <= hold - HOLD_ONE;
   end

   assign o_active = (hold != '0);

endmodule

// File: rtl/led_driver.sv
// rtl/led_driver.sv - LED drive from level requests and stretched event pulses
// Optional global PWM brightness gate compiled in with LED_DRIVER_PWM_EN.
module led_driver
   import led_driver_pkg::*;
#(
   parameter int NOUT   = 8,
   parameter int LGHOLD = DEFAULT_LGHOLD
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NOUT-1:0]   i_set,
   input  logic [NOUT-1:0]   i_pulse,
   input  logic [PWM_W-1:0]  i_brightness,
   output logic [NOUT-1:0]   o_led
);

   logic [NOUT-1:0] active;
   logic [NOUT-1:0] req;
   logic            pwm_on;

   for (genvar k = 0; k < NOUT; k++) begin : g_ch
      led_stretch #(
         .LGHOLD(LGHOLD)
      ) u_stretch (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_pulse  (i_pulse[k]),
         .o_active (active[k])
      );
   end

   // The current pulse is ORed in directly so the LED lights with 1-cycle latency.
   assign req = i_set | i_pulse | active;

`ifdef LED_DRIVER_PWM_EN
   logic [PWM_W-1:0] pwm_ctr;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         pwm_ctr <= '0;
      else
         pwm_ctr <= pwm_ctr + 8'd1;
   end

   assign pwm_on = pwm_gate(pwm_ctr, i_brightness);
`else
   logic unused_brightness;

   assign unused_brightness = &{1'b0, i_brightness};
   assign pwm_on            = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset)
         o_led <= '0;
      else
         o_led <= req & {NOUT{pwm_on}};
   end

endmodule

// File: tb/tb_led_driver.sv
// tb/tb_led_driver.sv - directed self-checking bench for led_driver (LGHOLD=4, NOUT=8)
module tb_led_driver;

   localparam int NOUT   = 8;
   localparam int LGHOLD = 4;

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic [NOUT-1:0] i_set;
   logic [NOUT-1:0] i_pulse;
   logic [7:0]      i_brightness;
   logic [NOUT-1:0] o_led;

   int tests_run    = 0;
   int tests_failed = 0;

   led_driver #(
      .NOUT   (NOUT),
      .LGHOLD (LGHOLD)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_set        (i_set),
      .i_pulse      (i_pulse),
      .i_brightness (i_brightness),
      .o_led        (o_led)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_set   = '0;
      i_pulse = '0;
      step();
      step();
      i_reset = 1'b0;
   endtask

   initial begin
      i_brightness = 8'd0;
      do_reset();
      check("reset_state", 32'(o_led), 32'h0);

      // Single pulse at c=0: on for c=1..16, off at 17.
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         i_pulse = (c == 0) ? 8'h01 : 8'h00;
         check($sformatf("single_c%0d", c), 32'(o_led), (c >= 1 && c <= 16) ? 32'h01 : 32'h0);
         step();
      end
      i_pulse = '0;

      // Retrigger at c=10 extends on-time to c=26.
      do_reset();
      for (int c = 0; c <= 27; c++) begin
         i_pulse = (c == 0 || c == 10) ? 8'h01 : 8'h00;
         check($sformatf("retrig_c%0d", c), 32'(o_led), (c >= 1 && c <= 26) ? 32'h01 : 32'h0);
         step();
      end
      i_pulse = '0;

      // Level request on bit 7 for three cycles.
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         i_set = (c < 3) ? 8'h80 : 8'h00;
         check($sformatf("level_c%0d", c), 32'(o_led), (c >= 1 && c <= 3) ? 32'h80 : 32'h0);
         step();
      end

      // Pulse on bit 1 in the cycle its set level drops: no gap, stretch ends at 4+16.
      do_reset();
      for (int c = 0; c <= 21; c++) begin
         i_set   = (c < 4)  ? 8'h02 : 8'h00;
         i_pulse = (c == 4) ? 8'h02 : 8'h00;
         check($sformatf("handoff_c%0d", c), 32'(o_led), (c >= 1 && c <= 20) ? 32'h02 : 32'h0);
         step();
      end
      i_set   = '0;
      i_pulse = '0;

      // Reset mid-hold clears it; LED stays dark until a new request.
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         i_pulse = (c == 0)  ? 8'h04 : 8'h00;
         i_reset = (c == 5);
         i_set   = (c == 31) ? 8'h04 : 8'h00;
         check($sformatf("rst_hold_c%0d", c), 32'(o_led),
               ((c >= 1 && c <= 5) || c == 32) ? 32'h04 : 32'h0);
         step();
      end
      i_reset = 1'b0;
      i_set   = '0;
      i_pulse = '0;

`ifdef LED_DRIVER_PWM_EN
      begin
         int         on_cnt [NOUT];
         logic [7:0] acc;

         do_reset();
         i_set        = 8'hff;
         i_brightness = 8'd64;
         step();
         step();
         for (int b = 0; b < NOUT; b++) on_cnt[b] = 0;
         for (int c = 0; c < 256; c++) begin
            for (int b = 0; b < NOUT; b++) on_cnt[b] += int'(o_led[b]);
            step();
         end
         for (int b = 0; b < NOUT; b++)
            check($sformatf("pwm64_bit%0d", b), 32'(on_cnt[b]), 32'd64);

         i_brightness = 8'd0;
         step();
         step();
         acc = 8'h00;
         for (int c = 0; c < 256; c++) begin
            acc |= o_led;
            step();
         end
         check("pwm0_or", 32'(acc), 32'h0);

         i_brightness = 8'hff;
         step();
         step();
         acc = 8'hff;
         for (int c = 0; c < 256; c++) begin
            acc &= o_led;
            step();
         end
         check("pwm255_and", 32'(acc), 32'hff);
         i_set = '0;
      end
`else
      do_reset();
      i_brightness = 8'd0;
      for (int c = 0; c <= 20; c++) begin
         i_set = 8'hff;
         check($sformatf("nopwm_c%0d", c), 32'(o_led), (c >= 1) ? 32'hff : 32'h0);
         step();
      end
      i_set = '0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
